// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the mips run controller: FSM states,
// halt-cause codes and a width helper.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [2:0] HC_NONE = 3'd0;
  localparam logic [2:0] HC_STEP = 3'd1;
  localparam logic [2:0] HC_REQ  = 3'd2;
  localparam logic [2:0] HC_BP   = 3'd3;
  localparam logic [2:0] HC_TMO  = 3'd4;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_match.sv
// PC breakpoint comparators with a lowest-index-wins priority encoder.
module bp_match
  import mips_dbg_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 2
) (
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  output logic                   hit,
  output logic [clog2(NUM_BP)-1:0] idx
);

  localparam int IDX_W = clog2(NUM_BP);

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the mips core: reset stretching, free-run / single-step,
// PC breakpoints, halt request, cycle-budget timeout and enabled-cycle count.
module mips_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32,
  parameter int NUM_BP       = 2,
  parameter int MAX_CYCLES   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step_mode,
  input  logic                     resume,
  input  logic                     halt_req,
  input  logic [PC_W-1:0]          pc,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [NUM_BP*PC_W-1:0]   bp_addr,
  output logic                     core_reset,
  output logic                     core_en,
  output logic                     halted,
  output logic [2:0]               halt_cause,
  output logic [clog2(NUM_BP)-1:0] bp_hit_idx,
  output logic [CNT_W-1:0]         cycle_cnt,
  output state_t                   dbg_state
);

  localparam int IDX_W = clog2(NUM_BP);
  localparam int RST_W = clog2(RESET_CYCLES);
  localparam logic [RST_W-1:0] RST_INIT = RST_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_AT =
    (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);

  state_t           state, state_n;
  logic [RST_W-1:0] rst_cnt, rst_cnt_n;
  logic             skip_bp, skip_bp_n;
  logic [2:0]       cause_n;
  logic [IDX_W-1:0] idx_n;
  logic [CNT_W-1:0] cnt_n;
  logic             bp_hit;
  logic [IDX_W-1:0] bp_idx;
  logic             tmo;

  bp_match #(.PC_W(PC_W), .NUM_BP(NUM_BP)) u_bp (
    .pc      (pc),
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .hit     (bp_hit),
    .idx     (bp_idx)
  );

  // >= rather than == so a resume after a timeout re-halts immediately.
  assign tmo = (MAX_CYCLES != 0) && (cycle_cnt >= TMO_AT);

  // resume is a one-cycle pulse honoured only while halted is high; there is
  // no other handshake, and halted rises the cycle after the halt condition.
  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    skip_bp_n = skip_bp;
    cause_n   = halt_cause;
    idx_n     = bp_hit_idx;
    cnt_n     = cycle_cnt;
    case (state)
      S_RST: begin
        if (rst_cnt == '0) begin
          state_n = step_mode ? S_HALT : S_RUN;
          cause_n = HC_NONE;
        end else begin
          rst_cnt_n = rst_cnt - 1'b1;
        end
      end
      S_RUN, S_STEP: begin
        if (!(&cycle_cnt)) cnt_n = cycle_cnt + 1'b1;
        skip_bp_n = 1'b0;
        if (tmo) begin
          state_n = S_HALT;
          cause_n = HC_TMO;
        end else if (bp_hit && !skip_bp) begin
          state_n = S_HALT;
          cause_n = HC_BP;
          idx_n   = bp_idx;
        end else if (state == S_RUN && halt_req) begin
          state_n = S_HALT;
          cause_n = HC_REQ;
        end else if (state == S_STEP) begin
          state_n = S_HALT;
          cause_n = HC_STEP;
        end
      end
      S_HALT: begin
        if (resume) begin
          state_n   = step_mode ? S_STEP : S_RUN;
          cause_n   = HC_NONE;
          skip_bp_n = 1'b1;
        end
      end
      default: state_n = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_RST;
      rst_cnt    <= RST_INIT;
      skip_bp    <= 1'b0;
      core_reset <= 1'b1;
      core_en    <= 1'b0;
      halted     <= 1'b0;
      halt_cause <= HC_NONE;
      bp_hit_idx <= '0;
      cycle_cnt  <= '0;
    end else begin
      state      <= state_n;
      rst_cnt    <= rst_cnt_n;
      skip_bp    <= skip_bp_n;
      core_reset <= (state_n == S_RST);
      core_en    <= (state_n == S_RUN) || (state_n == S_STEP);
      halted     <= (state_n == S_HALT);
      halt_cause <= cause_n;
      bp_hit_idx <= idx_n;
      cycle_cnt  <= cnt_n;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: halts are checked against an expected
// queue by a monitor; a second instance with MAX_CYCLES=3 covers timeout.
module tb_mips_run_ctrl;
  import mips_dbg_pkg::*;

  localparam int PC_W   = 32;
  localparam int CNT_W  = 32;
  localparam int NUM_BP = 2;
  localparam int IDX_W  = 1;
  localparam int EXP_W  = 3 + IDX_W + CNT_W;
  localparam logic [PC_W-1:0] BASE = 32'h0040_0000;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset, step_mode, resume, halt_req;
  logic [PC_W-1:0]        pc;
  logic [NUM_BP-1:0]      bp_en;
  logic [NUM_BP*PC_W-1:0] bp_addr;

  logic             core_reset, core_en, halted;
  logic [2:0]       halt_cause;
  logic [IDX_W-1:0] bp_hit_idx;
  logic [CNT_W-1:0] cycle_cnt;
  state_t           dbg_state;

  logic             core_reset_t, core_en_t, halted_t;
  logic [2:0]       halt_cause_t;
  logic [IDX_W-1:0] bp_hit_idx_t;
  logic [CNT_W-1:0] cycle_cnt_t;
  state_t           dbg_state_t;

  mips_run_ctrl #(.RESET_CYCLES(4), .PC_W(PC_W), .CNT_W(CNT_W),
                  .NUM_BP(NUM_BP), .MAX_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .step_mode(step_mode), .resume(resume),
    .halt_req(halt_req), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .core_reset(core_reset), .core_en(core_en), .halted(halted),
    .halt_cause(halt_cause), .bp_hit_idx(bp_hit_idx),
    .cycle_cnt(cycle_cnt), .dbg_state(dbg_state)
  );

  mips_run_ctrl #(.RESET_CYCLES(4), .PC_W(PC_W), .CNT_W(CNT_W),
                  .NUM_BP(NUM_BP), .MAX_CYCLES(3)) dut_t (
    .clk(clk), .reset(reset), .step_mode(step_mode), .resume(resume),
    .halt_req(halt_req), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
    .core_reset(core_reset_t), .core_en(core_en_t), .halted(halted_t),
    .halt_cause(halt_cause_t), .bp_hit_idx(bp_hit_idx_t),
    .cycle_cnt(cycle_cnt_t), .dbg_state(dbg_state_t)
  );

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle; pc advances like a core fetch whenever the cycle was enabled.
  task automatic cyc();
    logic e;
    e = core_en;
    @(negedge clk);
    if (e === 1'b1) pc = pc + 32'd4;
  endtask

  task automatic do_reset(input logic sm, output int n);
    reset = 1'b1;
    step_mode = sm;
    resume = 1'b0;
    halt_req = 1'b0;
    cyc();
    cyc();
    pc = BASE;
    reset = 1'b0;
    n = 0;
    while (core_reset && n < 20) begin
      n++;
      cyc();
    end
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (!halted && n < 50) begin
      n++;
      cyc();
    end
    checks++;
    if (!halted) begin
      errors++;
      $display("FAIL %s: got halted=0 after %0d cycles, expected halted=1", name, n);
    end
  endtask

  task automatic pulse_resume();
    resume = 1'b1;
    cyc();
    resume = 1'b0;
  endtask

  // monitor: every rising edge of halted consumes one expected record
  initial begin
    logic halted_q;
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] got;
    halted_q = 1'b0;
    forever begin
      @(negedge clk);
      if (halted === 1'b1 && halted_q !== 1'b1) begin
        checks++;
        got = {halt_cause, bp_hit_idx, cycle_cnt};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_halt: got cause=%0d idx=%0d cnt=%0d, expected no halt",
                   halt_cause, bp_hit_idx, cycle_cnt);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL halt_record: got cause=%0d idx=%0d cnt=%0d, expected cause=%0d idx=%0d cnt=%0d",
                     got[EXP_W-1 -: 3], got[CNT_W +: IDX_W], got[CNT_W-1:0],
                     e[EXP_W-1 -: 3], e[CNT_W +: IDX_W], e[CNT_W-1:0]);
          end
        end
      end
      halted_q = halted;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int n;
    int en_cnt;
    reset = 1'b1; step_mode = 1'b0; resume = 1'b0; halt_req = 1'b0;
    pc = BASE; bp_en = '0; bp_addr = '0;
    cyc();

    check("rst_core_reset", core_reset, 1);
    check("rst_core_en", core_en, 0);
    check("rst_halted", halted, 0);
    check("rst_cause", halt_cause, 0);
    check("rst_idx", bp_hit_idx, 0);
    check("rst_cnt", cycle_cnt, 0);
    check("rst_state", dbg_state, S_RST);

    // reset stretch, then breakpoint 0 at BASE+0x10
    bp_en = 2'b01;
    bp_addr = {32'h0000_0000, 32'h0040_0010};
    exp_q.push_back({HC_BP, 1'b0, 32'd5});
    do_reset(1'b0, n);
    check("rst_stretch_cycles", n, 4);
    check("run_core_en", core_en, 1);
    check("run_cnt0", cycle_cnt, 0);
    cyc();
    check("run_cnt1", cycle_cnt, 1);
    wait_halt("bp0_halt");
    check("bp0_core_en_off", core_en, 0);

    // resume from the breakpoint PC must not re-halt
    pc = 32'h0040_0010;
    pulse_resume();
    check("resume_cause_clr", halt_cause, HC_NONE);
    repeat (4) cyc();
    check("bp_skip_running", halted, 0);
    check("bp_skip_cnt", cycle_cnt, 9);

    // both breakpoints on the same address: lowest index wins; timeout beats bp
    bp_en = 2'b11;
    bp_addr = {32'h0040_0008, 32'h0040_0008};
    exp_q.push_back({HC_BP, 1'b0, 32'd3});
    do_reset(1'b0, n);
    wait_halt("bp_both_halt");
    check("tmo_halted", halted_t, 1);
    check("tmo_cause", halt_cause_t, HC_TMO);
    check("tmo_cnt", cycle_cnt_t, 3);
    pulse_resume();
    cyc();
    check("tmo_refire_halted", halted_t, 1);
    check("tmo_refire_cause", halt_cause_t, HC_TMO);
    check("tmo_refire_cnt", cycle_cnt_t, 4);

    // only breakpoint 1 reached first
    bp_addr = {32'h0040_0008, 32'h0040_000C};
    exp_q.push_back({HC_BP, 1'b1, 32'd3});
    do_reset(1'b0, n);
    wait_halt("bp1_halt");

    // single-step mode
    bp_en = 2'b00;
    exp_q.push_back({HC_NONE, 1'b0, 32'd0});
    do_reset(1'b1, n);
    check("step_init_halted", halted, 1);
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back({HC_STEP, 1'b0, CNT_W'(k)});
      en_cnt = 0;
      pulse_resume();
      for (int j = 0; j < 5; j++) begin
        if (core_en) en_cnt++;
        cyc();
      end
      check("step_en_cycles", en_cnt, 1);
      check("step_cause", halt_cause, HC_STEP);
    end
    check("step_cnt", cycle_cnt, 3);

    // halt request, then resume with the request still held
    do_reset(1'b0, n);
    repeat (3) cyc();
    check("req_pre_cnt", cycle_cnt, 3);
    exp_q.push_back({HC_REQ, 1'b0, 32'd4});
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    check("req_core_en_off", core_en, 0);
    exp_q.push_back({HC_REQ, 1'b0, 32'd5});
    halt_req = 1'b1;
    pulse_resume();
    check("req_resume_en", core_en, 1);
    cyc();
    check("req_rehalt_en_off", core_en, 0);
    halt_req = 1'b0;

    // reset mid-run
    do_reset(1'b0, n);
    repeat (17) cyc();
    check("midrun_cnt17", cycle_cnt, 17);
    reset = 1'b1;
    cyc();
    check("midrun_core_reset", core_reset, 1);
    check("midrun_core_en", core_en, 0);
    check("midrun_cnt", cycle_cnt, 0);
    check("midrun_cause", halt_cause, 0);
    check("midrun_state", dbg_state, S_RST);
    reset = 1'b0;

    repeat (3) cyc();
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Synthesizable run controller between the board/bench clock-reset source and the `mips` core.
- Drives the core's `reset` and `en` inputs.
- Adds behaviour a fixed clock/reset/enable harness lacks:
  - parametrised reset stretching,
  - free-run and single-step modes,
  - NUM_BP PC breakpoints,
  - halt request,
  - cycle-budget timeout,
  - enabled-cycle counter and halt-cause reporting.

Parameters:
- RESET_CYCLES, 4: cycles core_reset is held high after reset deasserts (>=1).
- PC_W, 32: program-counter width.
- CNT_W, 32: cycle counter width.
- NUM_BP, 2: number of PC breakpoint comparators (>=1).
- MAX_CYCLES, 0: enabled-cycle budget before timeout halt; 0 = unlimited.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- step_mode  in  1  0 = resume free-runs; 1 = resume executes one cycle.
- resume  in  1  single-cycle pulse; leaves HALT.
- halt_req  in  1  level; request halt while running.
- pc  in  PC_W  current fetch PC from core.
- bp_en  in  NUM_BP  per-breakpoint enable.
- bp_addr  in  NUM_BP*PC_W  breakpoint i at bits [i*PC_W +: PC_W].
- core_reset  out  1  reset to core.
- core_en  out  1  enable to core.
- halted  out  1  state == HALT.
- halt_cause  out  3  0 none, 1 step, 2 request, 3 breakpoint, 4 timeout.
- bp_hit_idx  out  clog2(NUM_BP) (min 1)  index of breakpoint that halted.
- cycle_cnt  out  CNT_W  count of cycles with core_en=1.

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - state=S_RST, core_reset=1, core_en=0, halted=0.
  - halt_cause=0, bp_hit_idx=0, cycle_cnt=0.
  - rst_cnt=RESET_CYCLES-1, skip_bp=0.
- Reset asserted in any state, mid-run included, returns here on the next edge.
- All outputs are registered.
- States:
  - S_RST: core_reset=1, core_en=0. rst_cnt decrements each cycle. At rst_cnt==0, go to S_RUN if step_mode=0, else S_HALT with cause 0. core_reset is therefore high for exactly RESET_CYCLES cycles after reset deasserts.
  - S_RUN: core_en=1, cycle_cnt increments (saturates at all-ones). Halt conditions are evaluated on the current pc/inputs each cycle.
  - Halt priority: timeout (MAX_CYCLES!=0 and cycle_cnt==MAX_CYCLES-1) > breakpoint (bp_en[i] && pc==bp_addr[i] && !skip_bp; lowest i wins) > halt_req.
  - On a halt condition: next state S_HALT, core_en=0 from the next cycle, halt_cause latched, bp_hit_idx latched on a breakpoint. The matching cycle itself is enabled.
  - S_HALT: core_en=0, halted=1, cycle_cnt frozen.
  - On resume in S_HALT: clear halt_cause, set skip_bp=1, go to S_RUN (step_mode=0) or S_STEP (step_mode=1). resume is ignored outside S_HALT.
  - Resume after timeout: if MAX_CYCLES!=0 and cycle_cnt>=MAX_CYCLES-1, the timeout re-fires immediately; cycle_cnt is not cleared except by reset.
  - S_STEP: core_en=1 for exactly one cycle, cycle_cnt+1, then S_HALT with cause 1. Timeout and breakpoint in that cycle override cause 1 under the priority above.
  - skip_bp: suppresses breakpoint matches for the first enabled cycle after resume only, so resuming from a breakpoint PC does not re-halt. Cleared after that cycle.
- halt_req held high while resuming: re-halts after one enabled cycle with cause 2.
- Simultaneous resume and halt_req in S_HALT: resume wins for that cycle; the halt is taken in the next S_RUN cycle.
- bp_en all zero and MAX_CYCLES=0: runs until halt_req or reset.

Decomposition:
- Shared package `mips_dbg_pkg`:
  - state encoding (S_RST, S_RUN, S_STEP, S_HALT),
  - halt-cause constants (HC_NONE, HC_STEP, HC_REQ, HC_BP, HC_TMO),
  - clog2 function.
- One sub-module: `bp_match`, parametrised PC_W/NUM_BP. Combinational compare plus priority encoder, giving hit and idx.

Test Plan:
- RESET_CYCLES=4, reset high 2 cycles then low → core_reset high exactly 4 cycles after deassert; core_en rises the next cycle; cycle_cnt increments from 0.
- bp_en=01, bp_addr[0]=0x0040_0010, pc sweeps by 4 from 0x0040_0000 → halt the cycle after pc==0x...10; halt_cause=3, bp_hit_idx=0, cycle_cnt=5. Pulse resume with pc unchanged → no re-halt, run continues.
- Both bps enabled, both addresses 0x0040_0008 → bp_hit_idx=0. MAX_CYCLES=3 with the same bp also hit at cycle 2 → halt_cause=4 (timeout wins).
- step_mode=1 after reset; issue 3 resume pulses spaced 5 cycles apart → each gives exactly one core_en cycle; cycle_cnt=3; halt_cause=1 after each.
- halt_req pulsed high in S_RUN → core_en low next cycle, cause 2. resume with halt_req still high → one enabled cycle, then halt cause 2.
- reset asserted mid-S_RUN with cycle_cnt=17 → next cycle: S_RST, cycle_cnt=0, core_reset=1, core_en=0, halt_cause=0.
